// File: rtl/roi_crop_axis.sv
// roi_crop_axis: crops a rectangular region of interest out of an AXI4-Stream
// video frame (tuser = start of frame, tlast = end of line). One output
// register stage; ROI corners are latched on each accepted start-of-frame beat.
module roi_crop_axis #(
  parameter int unsigned MAX_W   = 1920,
  parameter int unsigned MAX_H   = 1080,
  parameter int unsigned CH      = 3,
  parameter int unsigned CH_BITS = 8,
  parameter int unsigned CW      = $clog2((MAX_W > MAX_H) ? MAX_W : MAX_H)
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic [CH*CH_BITS-1:0] s_tdata_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  input  logic                  s_tuser_i,
  input  logic                  s_tlast_i,
  input  logic [CW-1:0]         roi_x0_i,
  input  logic [CW-1:0]         roi_y0_i,
  input  logic [CW-1:0]         roi_x1_i,
  input  logic [CW-1:0]         roi_y1_i,
  output logic [CH*CH_BITS-1:0] m_tdata_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic                  m_tuser_o,
  output logic                  m_tlast_o,
  output logic                  frame_done_o,
  output logic                  cfg_err_o,
  output logic                  sync_err_o
);

  localparam int unsigned DW = CH * CH_BITS;

  localparam logic [1:0] S_WAIT_SOF = 2'd0;
  localparam logic [1:0] S_ACTIVE   = 2'd1;
  localparam logic [1:0] S_SKIP     = 2'd2;

  // Limits widened by one bit so MAX_W/MAX_H stay representable.
  localparam logic [CW:0]   MAX_W_C = (CW+1)'(MAX_W);
  localparam logic [CW:0]   MAX_H_C = (CW+1)'(MAX_H);
  localparam logic [CW-1:0] X_LAST  = CW'(MAX_W - 1);
  localparam logic [CW-1:0] Y_SAT   = '1;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] r_x, r_y;
  logic          r_ovf;
  logic [CW-1:0] r_xl, r_xh, r_yl, r_yh;

  logic          r_m_tvalid;
  logic [DW-1:0] r_m_tdata;
  logic          r_m_tuser;
  logic          r_m_tlast;
  logic          r_m_eof;
  logic          r_frame_done;
  logic          r_cfg_err;
  logic          r_sync_err;

  logic          w_s_tready;
  logic          w_acc;
  logic          w_sof;
  logic [CW-1:0] w_in_xl, w_in_xh, w_in_yl, w_in_yh;
  logic          w_in_ok;
  logic [CW-1:0] w_xl, w_xh, w_yl, w_yh;
  logic [CW-1:0] w_x, w_y;
  logic          w_ovf;
  logic [1:0]    w_beat_state;
  logic          w_in_roi;
  logic          w_fwd;
  logic          w_last_px;
  logic          w_line_over;

  // Input handshake: the output slot is free or being drained this cycle.
  assign w_s_tready = !r_m_tvalid || m_tready_i;
  assign w_acc      = s_tvalid_i && w_s_tready;
  assign w_sof      = w_acc && s_tuser_i;

  // Normalised corners taken straight from the ports (used on the SOF beat).
  assign w_in_xl = (roi_x0_i <= roi_x1_i) ? roi_x0_i : roi_x1_i;
  assign w_in_xh = (roi_x0_i <= roi_x1_i) ? roi_x1_i : roi_x0_i;
  assign w_in_yl = (roi_y0_i <= roi_y1_i) ? roi_y0_i : roi_y1_i;
  assign w_in_yh = (roi_y0_i <= roi_y1_i) ? roi_y1_i : roi_y0_i;
  assign w_in_ok = ({1'b0, w_in_xh} < MAX_W_C) && ({1'b0, w_in_yh} < MAX_H_C);

  // Coordinates and ROI that apply to the beat currently on the input.
  assign w_xl  = w_sof ? w_in_xl : r_xl;
  assign w_xh  = w_sof ? w_in_xh : r_xh;
  assign w_yl  = w_sof ? w_in_yl : r_yl;
  assign w_yh  = w_sof ? w_in_yh : r_yh;
  assign w_x   = w_sof ? '0 : r_x;
  assign w_y   = w_sof ? '0 : r_y;
  assign w_ovf = w_sof ? 1'b0 : r_ovf;

  // State that governs the current beat; an SOF beat already belongs to the new frame.
  always_comb begin
    w_beat_state = r_state;
    if (w_sof) begin
      w_beat_state = w_in_ok ? S_ACTIVE : S_SKIP;
    end else if (r_state != S_ACTIVE && r_state != S_SKIP) begin
      w_beat_state = S_WAIT_SOF;
    end
  end

  assign w_in_roi    = (w_x >= w_xl) && (w_x <= w_xh) && (w_y >= w_yl) && (w_y <= w_yh);
  assign w_fwd       = w_acc && (w_beat_state == S_ACTIVE) && !w_ovf && w_in_roi;
  assign w_last_px   = (w_x == w_xh) && (w_y == w_yh);
  assign w_line_over = w_acc && !s_tlast_i && (w_x == X_LAST);

  // State register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) r_state <= S_WAIT_SOF;
    else        r_state <= w_state_nxt;
  end

  // Next state: follow the beat's state, return to WAIT_SOF after the last ROI pixel.
  always_comb begin
    w_state_nxt = r_state;
    if (w_acc) begin
      w_state_nxt = w_beat_state;
      if (w_fwd && w_last_px) w_state_nxt = S_WAIT_SOF;
    end
  end

  // Pixel position counters; x saturates on an over-long line until EOL.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_x   <= '0;
      r_y   <= '0;
      r_ovf <= 1'b0;
    end else if (w_acc) begin
      if (s_tlast_i) begin
        r_x   <= '0;
        r_y   <= (w_y == Y_SAT) ? w_y : w_y + CW'(1);
        r_ovf <= 1'b0;
      end else if (w_x == X_LAST) begin
        r_x   <= X_LAST;
        r_y   <= w_y;
        r_ovf <= 1'b1;
      end else begin
        r_x   <= w_x + CW'(1);
        r_y   <= w_y;
        r_ovf <= w_ovf;
      end
    end
  end

  // ROI corners are captured only on an accepted SOF beat.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_xl <= '0;
      r_xh <= '0;
      r_yl <= '0;
      r_yh <= '0;
    end else if (w_sof) begin
      r_xl <= w_in_xl;
      r_xh <= w_in_xh;
      r_yl <= w_in_yl;
      r_yh <= w_in_yh;
    end
  end

  // Output register stage; contents only change when a new beat is loaded.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tuser  <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_eof    <= 1'b0;
    end else if (w_fwd) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= s_tdata_i;
      r_m_tuser  <= (w_x == w_xl) && (w_y == w_yl);
      r_m_tlast  <= (w_x == w_xh);
      r_m_eof    <= w_last_px;
    end else if (m_tready_i) begin
      r_m_tvalid <= 1'b0;
    end
  end

  // Frame-done pulse and sticky error flags.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_frame_done <= r_m_tvalid && m_tready_i && r_m_eof;
      r_cfg_err    <= r_cfg_err | (w_sof && !w_in_ok);
      r_sync_err   <= r_sync_err
                    | (w_sof && (r_state == S_ACTIVE))
                    | (w_line_over && (w_beat_state != S_WAIT_SOF));
    end
  end

  assign s_tready_o   = w_s_tready;
  assign m_tvalid_o   = r_m_tvalid;
  assign m_tdata_o    = r_m_tdata;
  assign m_tuser_o    = r_m_tuser;
  assign m_tlast_o    = r_m_tlast;
  assign frame_done_o = r_frame_done;
  assign cfg_err_o    = r_cfg_err;
  assign sync_err_o   = r_sync_err;

endmodule

// File: doc/roi_crop_axis.md
ROI_CROP_AXIS -- requirements
Module: roi_crop_axis

Interface
REQ-001 Parameter MAX_W, default 1920: maximum frame width in pixels.
REQ-002 Parameter MAX_H, default 1080: maximum frame height in lines.
REQ-003 Parameter CH, default 3: channels per pixel.
REQ-004 Parameter CH_BITS, default 8: bits per channel.
REQ-005 Parameter CW, default $clog2(max(MAX_W,MAX_H)): coordinate width.
REQ-006 clk_i  in  1  clock; all logic on rising edge.
REQ-007 arst_i  in  1  reset, asynchronous, active-high.
REQ-008 s_tdata_i  in  CH*CH_BITS  input pixel; channel 0 in LSBs.
REQ-009 s_tvalid_i / s_tready_o  in / out  1 / 1  input handshake.
REQ-010 s_tuser_i  in  1  start of frame (SOF), set on first pixel of a frame.
REQ-011 s_tlast_i  in  1  end of line (EOL), set on last pixel of a line.
REQ-012 roi_x0_i, roi_y0_i, roi_x1_i, roi_y1_i  in  CW each  ROI corners, 0-based, inclusive, any order.
REQ-013 m_tdata_o  out  CH*CH_BITS  cropped pixel.
REQ-014 m_tvalid_o / m_tready_i  out / in  1 / 1  output handshake.
REQ-015 m_tuser_o  out  1  set on first ROI pixel of a frame.
REQ-016 m_tlast_o  out  1  set on last ROI pixel of each ROI line.
REQ-017 frame_done_o  out  1  one-cycle pulse after the last ROI pixel of a frame is accepted downstream.
REQ-018 cfg_err_o  out  1  sticky; ROI invalid at the latest SOF.
REQ-019 sync_err_o  out  1  sticky; SOF seen mid-frame or line longer than MAX_W.

Function
REQ-020 ROI corners shall be sampled only on an accepted SOF beat: xl=min(x0,x1), xh=max(x0,x1), yl/yh likewise; a mid-frame change shall have no effect.
REQ-021 ROI invalid when xh>=MAX_W or yh>=MAX_H; that frame shall be consumed with no output, and cfg_err_o set.
REQ-022 FSM states: WAIT_SOF (discard until SOF), ACTIVE (crop), SKIP (discard invalid-ROI frame until next SOF).
REQ-023 Transitions: WAIT_SOF->ACTIVE or SKIP on SOF per REQ-021; ACTIVE->WAIT_SOF after the beat at (xh,yh); SKIP->ACTIVE/SKIP on next SOF.
REQ-024 Counters x,y shall be 0 on the SOF beat; x increments per accepted beat; on EOL x<=0 and y++.
REQ-025 A beat shall be forwarded when state=ACTIVE and xl<=x<=xh and yl<=y<=yh.
REQ-026 m_tlast_o = (x==xh) on a forwarded beat; m_tuser_o = (x==xl && y==yl).
REQ-027 Output shall be a single register stage: a forwarded beat appears on m_* exactly 1 cycle after acceptance.
REQ-028 s_tready_o = !m_tvalid_o || m_tready_i; non-forwarded beats shall be accepted without an output slot.
REQ-029 m_tdata_o, m_tuser_o, m_tlast_o shall hold stable while m_tvalid_o=1 and m_tready_i=0.
REQ-030 Early EOL (line shorter than xh+1): the ROI line shall be truncated, no m_tlast_o emitted for it, no error.
REQ-031 x reaching MAX_W without EOL: x shall saturate at MAX_W-1, sync_err_o set, no further beats of that line forwarded.
REQ-032 SOF while ACTIVE before (xh,yh): the frame shall restart with new ROI per REQ-020, sync_err_o set.
REQ-033 Frame ending (next SOF) before yh: no frame_done_o for the truncated frame.
REQ-034 Arithmetic: comparisons unsigned on CW bits; x,y counters CW bits; no internal wrap inside a valid frame.
REQ-035 Simultaneous SOF and EOL on one beat (1-pixel line) shall be handled as both: x<=0, y<=1.

Reset
REQ-036 On arst_i: state=WAIT_SOF, x=y=0, m_tvalid_o=0, m_tuser_o=0, m_tlast_o=0, m_tdata_o=0, frame_done_o=0, cfg_err_o=0, sync_err_o=0.
REQ-037 Reset mid-frame shall drop any held output beat; after release, all beats before the next SOF shall be discarded.
REQ-038 s_tready_o shall be 1 during and after reset (output register empty).

Verification
REQ-039 8x4 frame, ROI (2,1)-(4,2), m_tready_i=1 -> 6 beats, each 1 cycle after its input, tlast at x=4, tuser on (2,1), one frame_done_o.
REQ-040 Same frame, corners given as (4,2),(2,1) -> identical output to REQ-039.
REQ-041 Random m_tready_i 50% -> s_tready_o follows REQ-028, no beat lost/duplicated, data stable while stalled.
REQ-042 ROI x1=MAX_W -> zero output beats, cfg_err_o=1; next frame with valid ROI crops correctly.
REQ-043 SOF injected at frame row 1 -> sync_err_o=1, restarted frame cropped correctly, no frame_done_o for the aborted frame.
REQ-044 arst_i pulsed during stalled output -> m_tvalid_o=0 immediately; pixels before next SOF never appear.
